// File: rtl/renode_apb3_arbiter.sv
// Round-robin arbiter sharing one APB3 completer among several requesters.
// Each grant is held for one full downstream SETUP/ACCESS transfer.
module renode_apb3_arbiter #(
    parameter int NumRequesters = 2,
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 0,
    localparam int IdWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
    input  logic                               pclk,
    input  logic                               presetn,
    input  logic [NumRequesters*AddressWidth-1:0] s_paddr,
    input  logic [NumRequesters-1:0]           s_psel,
    input  logic [NumRequesters-1:0]           s_penable,
    input  logic [NumRequesters-1:0]           s_pwrite,
    input  logic [NumRequesters*DataWidth-1:0] s_pwdata,
    output logic [NumRequesters-1:0]           s_pready,
    output logic [NumRequesters*DataWidth-1:0] s_prdata,
    output logic [NumRequesters-1:0]           s_pslverr,
    output logic [AddressWidth-1:0]            m_paddr,
    output logic                               m_psel,
    output logic                               m_penable,
    output logic                               m_pwrite,
    output logic [DataWidth-1:0]               m_pwdata,
    input  logic                               m_pready,
    input  logic [DataWidth-1:0]               m_prdata,
    input  logic                               m_pslverr,
    output logic                               grant_valid,
    output logic [IdWidth-1:0]                 grant_id
);

    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam bit WdEnable = (TimeoutCycles > 0);
    localparam logic [CntWidth-1:0] CntLast =
        WdEnable ? CntWidth'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t              state;
    logic [IdWidth-1:0]  last_grant;
    logic [IdWidth-1:0]  next_id;
    logic [CntWidth-1:0] wd_cnt;
    logic                any_req;
    logic                timeout_hit;
    logic                xfer_end;

    // Requesters' penable carries no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = ^s_penable;

    // Scan downward so the nearest pending index after last_grant wins.
    always_comb begin
        any_req = |s_psel;
        next_id = last_grant;
        for (int k = NumRequesters; k >= 1; k--) begin
            if (s_psel[(int'(last_grant) + k) % NumRequesters]) begin
                next_id = IdWidth'((int'(last_grant) + k) % NumRequesters);
            end
        end
    end

    assign timeout_hit = WdEnable && (state == S_ACCESS) &&
                         !m_pready && (wd_cnt == CntLast);
    assign xfer_end    = (state == S_ACCESS) && (m_pready || timeout_hit);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= S_IDLE;
            grant_id    <= '0;
            last_grant  <= IdWidth'(NumRequesters - 1);
            wd_cnt      <= '0;
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            grant_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id    <= next_id;
                        last_grant  <= next_id;
                        m_psel      <= 1'b1;
                        m_penable   <= 1'b0;
                        grant_valid <= 1'b1;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wd_cnt    <= '0;
                    m_penable <= 1'b1;
                    state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (xfer_end) begin
                        m_psel      <= 1'b0;
                        m_penable   <= 1'b0;
                        grant_valid <= 1'b0;
                        state       <= S_IDLE;
                    end else if (WdEnable) begin
                        wd_cnt <= wd_cnt + CntWidth'(1);
                    end
                end
                default: begin
                    m_psel      <= 1'b0;
                    m_penable   <= 1'b0;
                    grant_valid <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_paddr  = '0;
        m_pwrite = 1'b0;
        m_pwdata = '0;
        if (grant_valid) begin
            m_paddr  = s_paddr[int'(grant_id)*AddressWidth +: AddressWidth];
            m_pwrite = s_pwrite[grant_id];
            m_pwdata = s_pwdata[int'(grant_id)*DataWidth +: DataWidth];
        end
    end

    // A watchdog expiry completes with an error and zero read data.
    always_comb begin
        s_pready  = '0;
        s_prdata  = '0;
        s_pslverr = '0;
        if (state == S_ACCESS) begin
            s_pready[grant_id] = m_pready | timeout_hit;
            if (m_pready) begin
                s_prdata[int'(grant_id)*DataWidth +: DataWidth] = m_prdata;
                s_pslverr[grant_id] = m_pslverr;
            end else if (timeout_hit) begin
                s_pslverr[grant_id] = 1'b1;
            end
        end
    end

endmodule

// File: doc/renode_apb3_arbiter.md
Name: renode_apb3_arbiter

Overview:
- Shares one APB3 completer port among NumRequesters APB3 requesters, for example several renode requesters, or a CPU-side requester plus a DMA-side requester.
- Uses round-robin arbitration and holds each grant for one full APB transfer.
- Re-issues the granted transfer downstream with its own SETUP/ACCESS sequence and stalls all other requesters (pready low).
- Has an optional watchdog that terminates a hung downstream transfer with pslverr.

Parameters:
- NumRequesters, 2: number of upstream requester ports (1..16).
- AddressWidth, 20: paddr width.
- DataWidth, 32: pwdata/prdata width.
- TimeoutCycles, 0: maximum ACCESS cycles before forced error completion; 0 disables the watchdog.

Ports:
- pclk, input, 1: bus clock.
- presetn, input, 1: reset, asynchronous assert, active-low.
- s_paddr, input, NumRequesters*AddressWidth: requester addresses; lane i is bits [i*AddressWidth +: AddressWidth].
- s_psel, input, NumRequesters: requester select.
- s_penable, input, NumRequesters: requester enable.
- s_pwrite, input, NumRequesters: requester direction.
- s_pwdata, input, NumRequesters*DataWidth: requester write data.
- s_pready, output, NumRequesters: per-requester ready.
- s_prdata, output, NumRequesters*DataWidth: per-requester read data.
- s_pslverr, output, NumRequesters: per-requester error.
- m_paddr, output, AddressWidth: completer address.
- m_psel, output, 1: completer select.
- m_penable, output, 1: completer enable.
- m_pwrite, output, 1: completer direction.
- m_pwdata, output, DataWidth: completer write data.
- m_pready, input, 1: completer ready.
- m_prdata, input, DataWidth: completer read data.
- m_pslverr, input, 1: completer error.
- grant_valid, output, 1: a transfer is owned (state SETUP or ACCESS).
- grant_id, output, IdWidth = max(1, $clog2(NumRequesters)): index of the owning requester.

Behaviour:
- Reset (presetn low, asynchronous): state=S_IDLE, grant_id=0, last_grant=NumRequesters-1, timeout counter=0.
- During reset all outputs are 0: m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, all s_pready, s_prdata, s_pslverr, grant_valid.
- Reset mid-transfer abandons the transfer without an upstream response.
- After release, any requester still holding psel is re-arbitrated normally.
- Request: requester i is pending when s_psel[i]=1.
- States are S_IDLE, S_SETUP, S_ACCESS.
- S_IDLE:
  - If any request is pending, grant the first pending index searching upward from (last_grant+1) mod NumRequesters with wrap. Load grant_id and last_grant, then go to S_SETUP.
  - Otherwise stay in S_IDLE.
  - Immediately after reset, requester 0 has highest priority.
- S_SETUP: m_psel=1, m_penable=0; always go to S_ACCESS next cycle.
- S_ACCESS: m_psel=1, m_penable=1.
  - If m_pready=1: complete the transfer and return to S_IDLE. There is no direct ACCESS->SETUP path, so the completing requester cannot be re-granted on its stale psel.
  - Otherwise stay in S_ACCESS.
- Forwarding in S_SETUP/S_ACCESS: m_paddr, m_pwrite, m_pwdata are driven combinationally from lane grant_id. In S_IDLE they are 0.
- Upstream response:
  - s_pready[grant_id] = m_pready, only in S_ACCESS.
  - s_prdata[grant_id] = m_prdata and s_pslverr[grant_id] = m_pslverr, only in S_ACCESS with m_pready=1.
  - All other lanes and states drive 0.
- Minimum latency, from requester SETUP cycle to its completion: 3 cycles (arbitration, SETUP, ACCESS).
- Upstream protocol: the requester's SETUP overlaps arbitration or waiting. It then sits in ACCESS with pready=0 until completion. Requesters must keep paddr/pwrite/pwdata stable while psel=1, as APB3 requires.
- Watchdog (TimeoutCycles>0):
  - Counter clears on S_SETUP and increments each S_ACCESS cycle with m_pready=0.
  - When the counter reaches TimeoutCycles-1 with m_pready=0: drive s_pready[grant_id]=1, s_pslverr[grant_id]=1, s_prdata lane=0, and go to S_IDLE. Downstream psel drops the next cycle.
  - If m_pready=1 arrives on that same cycle, it wins: normal completion, m_pslverr passed through.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N-1,0. No requester waits for more than N-1 other transfers.
- NumRequesters=1: arbitration degenerates; the 3-cycle minimum latency still applies.

Test Plan:
- Single write: requester 0 writes addr 0x00104, data 0xDEADBEEF, completer pready=1 → m_psel high 2 cycles with m_penable on cycle 2; s_pready[0] pulses 1 cycle, 3 cycles after s_psel[0] rose; s_pready[1] stays 0.
- Simultaneous requests after reset: requesters 0 and 1 both request at once, completer ready → order 0 then 1; requester 1 waits with pready=0; grant_id sequence is 0,1; one S_IDLE cycle separates the two transfers.
- Round-robin fairness: N=3, all requesting back-to-back for 6 transfers → grant order 0,1,2,0,1,2; each requester's read returns its own m_prdata value (0x11, 0x22, 0x33 by address).
- Wait states and error: completer holds pready=0 for 4 ACCESS cycles, then pready=1 with pslverr=1 on a read of 0x00200 → requester sees pready=1, pslverr=1 after 4 stall cycles; m_paddr stable throughout.
- Timeout: TimeoutCycles=8, completer never asserts pready → after 8 ACCESS cycles requester gets pready=1, pslverr=1, prdata=0; m_psel=0 on the next cycle; a queued requester 1 is granted next.
- Reset mid-transfer: presetn pulsed low during S_ACCESS → all outputs 0 immediately (asynchronous); after release with s_psel[1] held, requester 1 is granted first (priority reset) and completes normally.
